// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: datapath width, reset vector, NOP encoding and
// the {pc, instr} fetch packet.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear and an occupancy count. DEPTH must be a power of two.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited request issue, in-order response tracking,
// redirect with stale-response discard, and a small instruction buffer feeding IF/ID.
module fetch_unit #(
  parameter int unsigned     XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(riscv_pkg::RESET_PC_DEFAULT),
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  output logic            if_flush
);

  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned DW = CW + 4;

  logic [XLEN-1:0]   pc_q, pc_d;
  logic [DW-1:0]     drop_q, drop_d;
  logic [CW-1:0]     infl_count, buf_count;
  logic [CW:0]       occupancy;
  logic [XLEN-1:0]   infl_head;
  logic [2*XLEN-1:0] buf_head;
  logic              infl_full, infl_empty, buf_full, buf_empty;
  logic              req_fire, drop_active, rsp_keep, buf_pop;
  logic              unused_flags;

  assign occupancy   = {1'b0, infl_count} + {1'b0, buf_count};
  assign imem_req_valid = !rst && !redirect_valid && (occupancy < (CW + 1)'(BUF_DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire    = imem_req_valid && imem_req_ready;

  // Responses already owed to a squashed stream are swallowed before any new one is kept.
  assign drop_active = (drop_q != '0);
  assign rsp_keep    = imem_rsp_valid && !drop_active && !redirect_valid;

  assign if_valid = !redirect_valid && !buf_empty;
  assign buf_pop  = if_valid && !stall;
  assign if_flush = redirect_valid && !rst;
  assign {if_pc, if_instr} = buf_empty ? '0 : buf_head;

  assign unused_flags = ^{infl_full, infl_empty, buf_full};

  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    if (redirect_valid) begin
      pc_d   = {redirect_pc[XLEN-1:2], 2'b00};
      drop_d = drop_q + DW'(infl_count) - DW'(imem_rsp_valid);
    end else begin
      if (req_fire) pc_d = pc_q + XLEN'(4);
      if (imem_rsp_valid && drop_active) drop_d = drop_q - DW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (BUF_DEPTH)
  ) u_infl_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect_valid),
    .push  (req_fire),
    .pop   (rsp_keep),
    .wdata (pc_q),
    .rdata (infl_head),
    .full  (infl_full),
    .empty (infl_empty),
    .count (infl_count)
  );

  sync_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (BUF_DEPTH)
  ) u_ibuf_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect_valid),
    .push  (rsp_keep),
    .pop   (buf_pop),
    .wdata ({infl_head, imem_rsp_data}),
    .rdata (buf_head),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_count)
  );

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32, address/instruction width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 Parameter BUF_DEPTH, default 2, max in-flight plus buffered instructions (power of two, >=2).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 redirect_valid  input  1  taken branch/jump from EX; redirect_pc  input  XLEN  target.
REQ-007 stall  input  1  downstream IF/ID register holding; current output not consumed.
REQ-008 imem_req_valid  output  1; imem_req_ready  input  1; imem_req_addr  output  XLEN.
REQ-009 imem_rsp_valid  input  1; imem_rsp_data  input  XLEN; responses in order, >=1 cycle after request acceptance, never back-pressured.
REQ-010 if_valid  output  1; if_pc  output  XLEN; if_instr  output  XLEN; feed IF/ID register d.
REQ-011 if_flush  output  1  drives IF/ID register flush.

Function
REQ-012 PC register SHALL hold the next fetch address; imem_req_addr SHALL equal PC.
REQ-013 imem_req_valid SHALL be 1 iff (outstanding + buffered) < BUF_DEPTH and redirect_valid=0.
REQ-014 Request accepted on imem_req_valid && imem_req_ready; PC SHALL advance by 4 that edge, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-015 Each accepted request SHALL push its address into an in-flight address FIFO; outstanding counter +1.
REQ-016 Each imem_rsp_valid SHALL pop the in-flight FIFO, outstanding -1; if drop counter=0, {addr, data} pushed to instruction buffer, else discarded and drop counter -1.
REQ-017 if_valid SHALL be 1 iff instruction buffer non-empty and redirect_valid=0; if_pc/if_instr SHALL be buffer head.
REQ-018 Buffer head SHALL pop on if_valid && !stall; with stall=1 outputs SHALL hold unchanged.
REQ-019 Response-to-if_valid latency SHALL be exactly 1 cycle (no bypass).
REQ-020 if_flush SHALL equal redirect_valid combinationally.
REQ-021 On redirect_valid edge: PC <= {redirect_pc[XLEN-1:2], 2'b00}; instruction buffer cleared; in-flight FIFO cleared; drop counter <= outstanding responses not arriving this cycle.
REQ-022 Redirect overrides stall and any same-cycle pop, push or request acceptance.
REQ-023 Simultaneous push and pop SHALL leave buffer occupancy unchanged; credit rule (REQ-013) SHALL make overflow impossible.
REQ-024 Redirect arriving while drop counter non-zero SHALL add outstanding count, never lose a pending discard.

Reset
REQ-025 While rst=1: PC=RESET_PC, imem_req_valid=0, if_valid=0, if_flush=0, if_pc=0, if_instr=0, counters/FIFOs empty.
REQ-026 Reset asserted mid-operation SHALL abandon in-flight requests; memory side is reset in the same domain.
REQ-027 imem_req_valid SHALL rise in the first cycle after rst deasserts.

Structure
REQ-028 XLEN, RESET_PC default, INSTR_NOP=32'h0000_0013 and the {pc,instr} fetch-packet typedef SHALL live in shared package riscv_pkg.
REQ-029 One sub-module sync_fifo (parameterised width/depth, push/pop/clear, full/empty), instantiated twice: in-flight addresses and instruction buffer.

Verification
REQ-030 Reset release, 1-cycle memory, ready=1, stall=0 -> imem_req_addr 0,4,8...; if_valid first high 2 cycles after release with if_pc=0.
REQ-031 stall=1 for 3 cycles with buffer full -> imem_req_valid=0, if_pc/if_instr constant, no dropped or duplicated instruction after release.
REQ-032 redirect_valid=1, redirect_pc=32'h0000_0103 with 2 outstanding -> if_flush=1 that cycle, next request addr 32'h0000_0100, both stale responses discarded, first if_pc=32'h0000_0100.
REQ-033 imem_req_ready=0 for 5 cycles -> PC stays, imem_req_addr stable, if_valid falls once buffer drains.
REQ-034 PC=32'hFFFF_FFFC accepted -> next imem_req_addr=32'h0000_0000.
REQ-035 rst pulsed mid-stream with 2 outstanding -> all outputs at reset values immediately; fetch restarts at RESET_PC.
